// File: rtl/axis_requant_stage.sv
// Requantization stage: arithmetic right shift then saturation to OUT_W bits, with frame checking.
// Build option: define RQ_ROUND_EN to round half up before shifting (default build truncates).
module axis_requant_stage #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned N       = 4,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               clear,
    input  logic               s_axis_tvalid,
    input  logic [ACC_W-1:0]   s_axis_tdata,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic               m_axis_tvalid,
    output logic [OUT_W-1:0]   m_axis_tdata,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic               frame_err,
    output logic [15:0]        sat_cnt
);

    localparam int unsigned Beats = N * N;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0]      LastIdx  = CntW'(Beats - 1);
    localparam logic [SHIFT_W-1:0]   MaxShift = SHIFT_W'(ACC_W - 1);
    localparam logic signed [ACC_W:0] SatMax  =
        signed'((ACC_W + 1)'((64'd1 << (OUT_W - 1)) - 64'd1));
    localparam logic signed [ACC_W:0] SatMin  = ~SatMax;

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SHIFT_W-1:0]   fshift_q, fshift_d;
    logic                 err_q, err_d;
    logic [15:0]          sat_cnt_q, sat_cnt_d;

    logic                 s1_valid_q, s1_valid_d;
    logic signed [ACC_W:0] s1_data_q, s1_data_d;
    logic                 s1_last_q, s1_last_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]     s2_data_q, s2_data_d;
    logic                 s2_last_q, s2_last_d;
    logic                 s2_sat_q, s2_sat_d;

    logic                 s1_adv, s2_adv, s_fire, m_fire, last_elem, beat_last;
    logic [SHIFT_W-1:0]   shift_sel, shift_eff;
    logic signed [ACC_W:0] acc_ext, rnd, shifted;

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign s2_adv        = ~s2_valid_q | m_axis_tready;
    assign s1_adv        = ~s1_valid_q | s2_adv;
    assign s_axis_tready = s1_adv & rst_n;
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign m_fire        = s2_valid_q & m_axis_tready;
    assign last_elem     = (cnt_q == LastIdx);
    assign beat_last     = s_axis_tlast | last_elem;

    always_comb begin
        shift_sel = (cnt_q == '0) ? shift : fshift_q;
        shift_eff = (32'(shift_sel) >= ACC_W) ? MaxShift : shift_sel;
        acc_ext   = {s_axis_tdata[ACC_W-1], s_axis_tdata};
        rnd       = '0;
`ifdef RQ_ROUND_EN
        if (shift_eff != '0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (shift_eff - SHIFT_W'(1));
        end
`endif
        // One extra bit of headroom keeps the rounding add from wrapping.
        shifted = (acc_ext + rnd) >>> shift_eff;
    end

    always_comb begin
        cnt_d      = cnt_q;
        fshift_d   = fshift_q;
        err_d      = err_q;
        sat_cnt_d  = sat_cnt_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        s2_sat_d   = s2_sat_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_last_d = s1_last_q;
                if (s1_data_q > SatMax) begin
                    s2_data_d = OUT_W'(SatMax);
                    s2_sat_d  = 1'b1;
                end else if (s1_data_q < SatMin) begin
                    s2_data_d = OUT_W'(SatMin);
                    s2_sat_d  = 1'b1;
                end else begin
                    s2_data_d = OUT_W'(s1_data_q);
                    s2_sat_d  = 1'b0;
                end
            end
        end

        if (s1_adv) begin
            s1_valid_d = s_fire;
            if (s_fire) begin
                s1_data_d = shifted;
                s1_last_d = beat_last;
            end
        end

        if (s_fire) begin
            if (cnt_q == '0) begin
                fshift_d = shift_eff;
            end
            cnt_d = beat_last ? '0 : cnt_q + CntW'(1);
            if (s_axis_tlast != last_elem) begin
                err_d = 1'b1;
            end
        end

        if (m_fire && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end

        if (clear) begin
            cnt_d     = '0;
            err_d     = 1'b0;
            sat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            fshift_q   <= '0;
            err_q      <= 1'b0;
            sat_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
            s2_sat_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            fshift_q   <= fshift_d;
            err_q      <= err_d;
            sat_cnt_q  <= sat_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    assign m_axis_tvalid = s2_valid_q;
    assign m_axis_tdata  = s2_data_q;
    assign m_axis_tlast  = s2_last_q;
    assign frame_err     = err_q;
    assign sat_cnt       = sat_cnt_q;

endmodule

// File: tb/tb_axis_requant_stage.sv
// Bench for axis_requant_stage: vector table, directed framing/reset sequences, random traffic
// checked every cycle against an arithmetic reference model and scoreboard.
module tb_axis_requant_stage;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 16;
    localparam int N       = 4;
    localparam int SHIFT_W = 5;
`ifdef RQ_ROUND_EN
    localparam bit Rnd = 1'b1;
`else
    localparam bit Rnd = 1'b0;
`endif
    localparam longint MaxOut = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint MinOut = -MaxOut - 1;

    logic               clk;
    logic               rst_n;
    logic [SHIFT_W-1:0] shift;
    logic               clear;
    logic               s_axis_tvalid;
    logic [ACC_W-1:0]   s_axis_tdata;
    logic               s_axis_tlast;
    logic               s_axis_tready;
    logic               m_axis_tvalid;
    logic [OUT_W-1:0]   m_axis_tdata;
    logic               m_axis_tlast;
    logic               m_axis_tready;
    logic               frame_err;
    logic [15:0]        sat_cnt;

    axis_requant_stage #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .N      (N),
        .SHIFT_W(SHIFT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .shift        (shift),
        .clear        (clear),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .frame_err    (frame_err),
        .sat_cnt      (sat_cnt)
    );

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
        bit               sat;
    } exp_t;

    typedef struct {
        int               sh;
        logic [ACC_W-1:0] din;
        logic [OUT_W-1:0] dout;
        bit               sat;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_mode   = 0;
    exp_t sbq[$];
    int   m_idx    = 0;
    int   m_fshift = 0;
    bit   m_err    = 0;
    int   m_sat    = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    bit   prev_stall = 0;
    logic [OUT_W-1:0] prev_d;
    logic prev_l;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail(input string name, input logic [63:0] got, input logic [63:0] exp);
        failures++;
        $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) fail(name, got, exp);
    endtask

    // Floor-division reference with optional half-up rounding, then clipping.
    function automatic void ref_model(input logic [ACC_W-1:0] d, input int sh,
                                      output logic [OUT_W-1:0] y, output bit sat);
        longint x, p, q;
        int     s;
        s = (sh > ACC_W - 1) ? ACC_W - 1 : sh;
        x = longint'($signed(d));
        p = longint'(1) << s;
        if (Rnd && s > 0) x = x + p / 2;
        q = x / p;
        if (x < 0 && (x % p) != 0) q = q - 1;
        sat = 1'b0;
        if (q > MaxOut) begin
            y = OUT_W'(MaxOut);
            sat = 1'b1;
        end else if (q < MinOut) begin
            y = OUT_W'(MinOut);
            sat = 1'b1;
        end else begin
            y = OUT_W'(q);
        end
    endfunction

    task automatic monitor_step();
        exp_t e;
        logic [OUT_W-1:0] y;
        bit sat;
        if (!rst_n) begin
            sbq.delete();
            m_idx = 0; m_fshift = 0; m_err = 0; m_sat = 0; prev_stall = 0;
            return;
        end
        chk("frame_err", frame_err, m_err);
        chk("sat_cnt", sat_cnt, m_sat);
        chk("s_tready", s_axis_tready, (sbq.size() < 2) || m_axis_tready);
        if (prev_stall) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, prev_d);
            chk("stall_last", m_axis_tlast, prev_l);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (sbq.size() == 0) begin
                checks++;
                fail("spurious_out", m_axis_tdata, 0);
            end else begin
                e = sbq.pop_front();
                chk("out_data", m_axis_tdata, e.d);
                chk("out_last", m_axis_tlast, e.l);
                n_out++;
                if (e.sat && !clear && m_sat < 65535) m_sat++;
            end
        end
        if (s_axis_tvalid && s_axis_tready) begin
            if (m_idx == 0) m_fshift = int'(shift);
            ref_model(s_axis_tdata, m_fshift, y, sat);
            e.d = y;
            e.sat = sat;
            e.l = s_axis_tlast || (m_idx == N * N - 1);
            sbq.push_back(e);
            n_in++;
            if (!clear && (s_axis_tlast != (m_idx == N * N - 1))) m_err = 1;
            m_idx = e.l ? 0 : m_idx + 1;
        end
        if (clear) begin
            m_idx = 0; m_err = 0; m_sat = 0;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (m_mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ACC_W-1:0] d, input logic l);
        int t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            t++;
            if (t > 200) begin
                checks++;
                fail("send_timeout", t, 0);
                break;
            end
        end
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic logic [ACC_W-1:0] rand_data();
        if ($urandom_range(0, 1) == 0) return ACC_W'($urandom);
        return ACC_W'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
    endfunction

    task automatic rand_frame();
        shift = SHIFT_W'($urandom_range(0, 20));
        for (int i = 0; i < N * N; i++) begin
            if (i == 3) shift = SHIFT_W'($urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) tick();
            send(rand_data(), i == N * N - 1);
        end
    endtask

    vec_t vecs[15];

    initial begin
        int c0;
        int t;
        vecs[0]  = '{0,  32'h0000_0005, 16'h0005, 1'b0};
        vecs[1]  = '{4,  32'h0000_1238, Rnd ? 16'h0124 : 16'h0123, 1'b0};
        vecs[2]  = '{4,  32'hFFFF_FFF8, Rnd ? 16'h0000 : 16'hFFFF, 1'b0};
        vecs[3]  = '{0,  32'h0001_0000, 16'h7FFF, 1'b1};
        vecs[4]  = '{0,  32'hFFFF_0000, 16'h8000, 1'b1};
        vecs[5]  = '{0,  32'h0000_7FFF, 16'h7FFF, 1'b0};
        vecs[6]  = '{0,  32'hFFFF_8000, 16'h8000, 1'b0};
        vecs[7]  = '{31, 32'h8000_0000, 16'hFFFF, 1'b0};
        vecs[8]  = '{16, 32'h7FFF_FFFF, 16'h7FFF, Rnd};
        vecs[9]  = '{1,  32'h0000_0003, Rnd ? 16'h0002 : 16'h0001, 1'b0};
        vecs[10] = '{8,  32'hFFFF_FF80, Rnd ? 16'h0000 : 16'hFFFF, 1'b0};
        vecs[11] = '{20, 32'h1234_5678, 16'h0123, 1'b0};
        vecs[12] = '{15, 32'hFFFE_0000, 16'hFFFC, 1'b0};
        vecs[13] = '{2,  32'h0001_FFFF, 16'h7FFF, Rnd};
        vecs[14] = '{2,  32'hFFFD_FFFC, 16'h8000, 1'b1};

        rst_n = 1'b0; shift = '0; clear = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        #12;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        tick();
        rst_n = 1'b1;

        // Ramp frame: latency and full throughput.
        shift = '0;
        c0 = cyc;
        send(32'd0, 1'b0);
        chk("lat_s1_only", m_axis_tvalid, 0);
        send(32'd1, 1'b0);
        chk("lat_2cyc_valid", m_axis_tvalid, 1);
        chk("lat_2cyc_data", m_axis_tdata, 0);
        for (int i = 2; i < N * N; i++) send(ACC_W'(i), i == N * N - 1);
        chk("throughput_cycles", cyc - c0, N * N);
        drain();
        chk("ramp_frame_err", frame_err, 0);
        chk("ramp_sat_cnt", sat_cnt, 0);

        // Vector table, each as element 0 of a freshly cleared frame.
        for (int v = 0; v < 15; v++) begin
            shift = SHIFT_W'(vecs[v].sh);
            pulse_clear();
            send(vecs[v].din, 1'b0);
            t = 0;
            while (!m_axis_tvalid && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("vec%0d_data", v), m_axis_tdata, vecs[v].dout);
            tick();
            chk($sformatf("vec%0d_sat", v), sat_cnt, vecs[v].sat);
        end

        // Two clipped beats then clear.
        shift = '0;
        pulse_clear();
        send(32'h0001_0000, 1'b0);
        send(32'hFFFF_0000, 1'b0);
        drain();
        chk("sat_two", sat_cnt, 2);
        pulse_clear();
        chk("sat_cleared", sat_cnt, 0);

        // Random traffic under toggling, then random, output ready.
        m_mode = 1;
        repeat (3) rand_frame();
        m_mode = 2;
        repeat (3) rand_frame();
        drain();
        m_mode = 0;
        tick();
        chk("rand_no_frame_err", frame_err, 0);
        chk("rand_in_eq_out", n_in, n_out);

        // Early tlast, then a correct frame with a mid-frame shift change.
        shift = SHIFT_W'(2);
        for (int i = 0; i < 10; i++) send(ACC_W'(i * 1000), i == 9);
        drain();
        chk("early_tlast_err", frame_err, 1);
        shift = SHIFT_W'(3);
        for (int i = 0; i < N * N; i++) begin
            if (i == 3) shift = SHIFT_W'(9);
            send(ACC_W'(i * 777), i == N * N - 1);
        end
        drain();
        chk("err_sticky", frame_err, 1);
        pulse_clear();
        chk("err_cleared", frame_err, 0);

        // Missing tlast: the frame is still closed at the 16th beat.
        shift = '0;
        for (int i = 0; i < N * N; i++) send(ACC_W'(i), 1'b0);
        drain();
        chk("missing_tlast_err", frame_err, 1);

        // Reset mid-frame with clipped beats in flight.
        for (int i = 0; i < 5; i++) send(32'h0001_0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_m_tvalid", m_axis_tvalid, 0);
        chk("mrst_m_tdata", m_axis_tdata, 0);
        chk("mrst_m_tlast", m_axis_tlast, 0);
        chk("mrst_frame_err", frame_err, 0);
        chk("mrst_sat_cnt", sat_cnt, 0);
        chk("mrst_s_tready", s_axis_tready, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N * N; i++) send(ACC_W'(i + 50), i == N * N - 1);
        drain();
        chk("post_rst_frame_err", frame_err, 0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
